// File: rtl/ir_move_receiver.sv
// ir_move_receiver
//   Rover-side responder for the IR move-command link. Decodes a 12-bit move
//   frame {turn[11:8], dist[7:0]} sent LSB-first as mark-length coded bits.
//   It then spins clockwise for turn*TURN_STEP cycles and drives forward for
//   dist*DRIVE_FACTOR cycles.
//
// Ports
//   clock        in   system clock
//   reset        in   synchronous, active-high
//   ir_in        in   demodulated IR, active-low (0 = mark), asynchronous
//   cmd_valid    out  1-cycle pulse when a full frame has been decoded
//   cmd_out      out  last decoded command, held until the next valid frame
//   frame_error  out  1-cycle pulse when a frame is aborted
//   busy         out  high while executing a move (TURN or DRIVE)
//   motor_left   out  {fwd,rev} for the left H-bridge
//   motor_right  out  {fwd,rev} for the right H-bridge
module ir_move_receiver #(
    parameter int unsigned MARK_MIN     = 8100,
    parameter int unsigned ONE_MIN      = 24300,
    parameter int unsigned START_MIN    = 48600,
    parameter int unsigned MARK_MAX     = 81000,
    parameter int unsigned SPACE_MAX    = 32400,
    parameter int unsigned TURN_STEP    = 13500000,
    parameter int unsigned DRIVE_FACTOR = 27000000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ir_in,
    output logic        cmd_valid,
    output logic [11:0] cmd_out,
    output logic        frame_error,
    output logic        busy,
    output logic [1:0]  motor_left,
    output logic [1:0]  motor_right
);

    localparam int CNT_W = $clog2(MARK_MAX + 2);

    localparam logic [CNT_W-1:0] LEN_SAT     = CNT_W'(MARK_MAX + 1);
    localparam logic [CNT_W-1:0] LEN_MIN     = CNT_W'(MARK_MIN);
    localparam logic [CNT_W-1:0] LEN_ONE     = CNT_W'(ONE_MIN);
    localparam logic [CNT_W-1:0] LEN_START   = CNT_W'(START_MIN);
    localparam logic [CNT_W-1:0] LEN_MAX     = CNT_W'(MARK_MAX);
    localparam logic [CNT_W-1:0] LEN_SPC_MAX = CNT_W'(SPACE_MAX);

    typedef enum logic [2:0] {
        IDLE,
        START,
        SPACE,
        MARK,
        LATCH,
        TURN,
        DRIVE
    } state_t;

    state_t           state;
    logic             ir_meta;
    logic             ir_sync;
    logic             ir_prev;
    logic             fall_edge;
    logic             rise_edge;
    logic [CNT_W-1:0] len;
    logic [CNT_W-1:0] len_inc;
    logic [11:0]      shift;
    logic [3:0]       bit_idx;
    logic [33:0]      exec_cnt;
    logic [33:0]      turn_cycles;
    logic [33:0]      drive_cycles;

    // Edges are taken on the synchronized level, so a mark entering the
    // decoder is exactly as long (in cycles) as the raw mark.
    assign fall_edge = ir_prev & ~ir_sync;
    assign rise_edge = ~ir_prev & ir_sync;

    // Length counter saturates one past MARK_MAX so "too long" stays visible.
    assign len_inc = (len == LEN_SAT) ? len : len + 1'b1;

    // The shift register is only written while decoding, so it still holds
    // the executing command during TURN/DRIVE.
    assign turn_cycles  = 34'(shift[11:8]) * 34'(TURN_STEP);
    assign drive_cycles = 34'(shift[7:0]) * 34'(DRIVE_FACTOR);

    assign busy = (state == TURN) || (state == DRIVE);

    always_ff @(posedge clock) begin
        if (reset) begin
            ir_meta     <= 1'b1;
            ir_sync     <= 1'b1;
            ir_prev     <= 1'b1;
            state       <= IDLE;
            len         <= '0;
            shift       <= '0;
            bit_idx     <= '0;
            exec_cnt    <= '0;
            cmd_valid   <= 1'b0;
            cmd_out     <= '0;
            frame_error <= 1'b0;
            motor_left  <= 2'b00;
            motor_right <= 2'b00;
        end else begin
            ir_meta     <= ir_in;
            ir_sync     <= ir_meta;
            ir_prev     <= ir_sync;
            cmd_valid   <= 1'b0;
            frame_error <= 1'b0;

            // Motors follow the current state, one cycle behind it.
            case (state)
                TURN: begin
                    motor_left  <= 2'b10;
                    motor_right <= 2'b01;
                end
                DRIVE: begin
                    motor_left  <= 2'b10;
                    motor_right <= 2'b10;
                end
                default: begin
                    motor_left  <= 2'b00;
                    motor_right <= 2'b00;
                end
            endcase

            case (state)
                IDLE: begin
                    if (fall_edge) begin
                        state <= START;
                        len   <= 1;
                    end
                end

                START: begin
                    if (len > LEN_MAX) begin
                        state       <= IDLE;
                        frame_error <= 1'b1;
                    end else if (rise_edge) begin
                        // A short mark in IDLE is treated as noise, not an error.
                        if (len >= LEN_START) begin
                            state   <= SPACE;
                            len     <= 1;
                            bit_idx <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        len <= len_inc;
                    end
                end

                SPACE: begin
                    if (fall_edge) begin
                        state <= MARK;
                        len   <= 1;
                    end else if (len >= LEN_SPC_MAX) begin
                        state       <= IDLE;
                        frame_error <= 1'b1;
                    end else begin
                        len <= len_inc;
                    end
                end

                MARK: begin
                    // Overlong marks abort immediately rather than at the rising edge.
                    if (len > LEN_MAX) begin
                        state       <= IDLE;
                        frame_error <= 1'b1;
                    end else if (rise_edge) begin
                        if (len < LEN_MIN) begin
                            state       <= IDLE;
                            frame_error <= 1'b1;
                        end else begin
                            shift <= {(len >= LEN_ONE), shift[11:1]};
                            if (bit_idx == 4'd11) begin
                                state <= LATCH;
                            end else begin
                                state   <= SPACE;
                                len     <= 1;
                                bit_idx <= bit_idx + 4'd1;
                            end
                        end
                    end else begin
                        len <= len_inc;
                    end
                end

                LATCH: begin
                    cmd_out   <= shift;
                    cmd_valid <= 1'b1;
                    if (shift[11:8] != 4'd0) begin
                        state    <= TURN;
                        exec_cnt <= turn_cycles;
                    end else if (shift[7:0] != 8'd0) begin
                        state    <= DRIVE;
                        exec_cnt <= drive_cycles;
                    end else begin
                        state <= IDLE;
                    end
                end

                TURN: begin
                    if (exec_cnt <= 34'd1) begin
                        if (shift[7:0] != 8'd0) begin
                            state    <= DRIVE;
                            exec_cnt <= drive_cycles;
                        end else begin
                            state    <= IDLE;
                            exec_cnt <= '0;
                        end
                    end else begin
                        exec_cnt <= exec_cnt - 34'd1;
                    end
                end

                DRIVE: begin
                    if (exec_cnt <= 34'd1) begin
                        state    <= IDLE;
                        exec_cnt <= '0;
                    end else begin
                        exec_cnt <= exec_cnt - 34'd1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
